frame_edge_packer: RTL and testbench
====================================

Name: frame_edge_packer

Overview:
Output stage between the multi-channel convolution/magnitude datapath and the UART TX path. It thresholds an OutChannels-wide signed feature vector into one edge bit per pixel, using a run-time selectable mode and threshold. It packs BusWidth bits per byte and appends a two-byte tail per frame. Mode and threshold are latched only at frame boundaries, so a frame is never mixed-mode, and a frame whose element count is not a multiple of BusWidth is padded.

Parameters:
- Channels, 2, number of signed input channels.
- ChanWidth, 5, width of each signed channel value.
- BusWidth, 8, output byte width; also the number of pixels packed per byte.
- PacketLenElems, 318*238, pixels per frame.
- TailByte0, 8'hA5, first tail byte.
- TailByte1, 8'h5A, second tail byte.
- ModeWidth, $clog2(2*Channels+1), width of the mode select.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, reset; asynchronous, active-high.
- mode_i, in, ModeWidth, requested mode; sampled at frame start.
- thresh_i, in, ChanWidth, unsigned threshold; sampled at frame start.
- valid_i, in, 1, input pixel valid.
- ready_o, out, 1, input pixel accepted when valid_i && ready_o.
- data_i, in, Channels*ChanWidth, packed signed channels; channel c occupies [c*ChanWidth +: ChanWidth].
- valid_o, out, 1, output byte valid.
- ready_i, in, 1, downstream ready.
- data_o, out, BusWidth, output byte.
- mode_active_o, out, ModeWidth, mode in effect for the current frame.
- frame_count_o, out, 16, count of completed frames; wraps at 16'hFFFF.

Behaviour:
- Reset (async assert, sync release): state=S_DATA, counters=0, shift register=0, valid_o=0, data_o=0, mode_active_o=0, threshold register=0, frame_count_o=0.
- Mode encoding, computed on the latched mode m and threshold T:
  - m<Channels: bit = ($signed(ch[m]) >= $signed({1'b0,T})).
  - Channels<=m<2*Channels: bit = (|ch[m-Channels]| >= T). Compute |x| at ChanWidth+1 bits so the most negative value is handled without overflow.
  - m==2*Channels: bit = OR of |ch[c]|>=T over all channels.
  - m>2*Channels: treated as m==2*Channels.
- Latching: mode_i and thresh_i are captured on the accept of element 0 of a frame (elem_cnt==0). The captured values are used for that element and for the rest of the frame. mode_active_o shows the latched value.
- Packing: the first pixel of each byte goes to bit 0 (LSB first). bit_cnt runs 0..BusWidth-1. When the BusWidth-th bit is accepted, the byte is loaded into the output register.
- Output register: a single slot. valid_o stays high until ready_i. data_o must be stable while valid_o && !ready_i.
- ready_o = (state==S_DATA) && (!valid_o || bit_cnt != BusWidth-1 || ready_i-independent term false).
  - Concretely: ready_o = state==S_DATA && !(valid_o && bit_cnt==BusWidth-1).
  - There is no combinational path from ready_i to ready_o.
- State machine:
  - S_DATA: accept pixels. On the accept of element PacketLenElems-1:
    - if the byte is complete, load it and go to S_TAIL0;
    - otherwise go to S_FLUSH.
  - S_FLUSH: when the slot is free, load the partial byte with the upper bits zero-padded, then go to S_TAIL0.
  - S_TAIL0: when the slot is free (or freeing this cycle), load TailByte0 and go to S_TAIL1.
  - S_TAIL1: load TailByte1, increment frame_count_o, clear elem_cnt and bit_cnt, then go to S_DATA.
- Latency: a completed byte appears on valid_o the cycle after its last bit is accepted. The tail bytes are back-to-back when ready_i is held high.
- Load-while-draining: the output slot may be reloaded in the same cycle it is drained (valid_o && ready_i). This gives full throughput of one byte per cycle.
- Boundary cases:
  - PacketLenElems%BusWidth==0: S_FLUSH is never entered.
  - PacketLenElems<BusWidth: a single padded byte is sent, then the tail.
  - A mode_i change mid-frame has no effect until the next frame.
  - Reset mid-frame discards the partial byte and the pending output byte, and frame_count_o returns to 0.

Decomposition:
- Package frame_pkg:
  - state enum (S_DATA, S_FLUSH, S_TAIL0, S_TAIL1);
  - default tail constants 8'hA5 and 8'h5A, shared with framer/deframer.
- One natural sub-module, edge_threshold: combinational mode/threshold to a single bit. Instantiate it once.

Test Plan:
- Channels=2, ChanWidth=5, PacketLenElems=16, m=0, T=2, ch0 sequence {2,1,-3,5,0,2,2,-16,…}. Expect the first byte = 8'b0110_1001 → bytes then A5, 5A; frame_count_o=1.
- Same setup with m=2 (|ch0|) and ch0=-16 on every pixel, T=15. Expect all bytes 8'hFF, confirming no overflow on the absolute value.
- PacketLenElems=10, all pixels 1 under m=4 (OR). Expect FF, 03, A5, 5A; S_FLUSH is exercised.
- Change mode_i from 0 to 1 at element 5 of a 16-element frame. Expect mode_active_o to hold 0 until the next frame's element 0, and frame 1 bytes to be computed wholly with m=0.
- Hold ready_i low for 20 cycles with valid_i high. Expect ready_o to drop when the next byte completes, data_o to stay stable, and no pixel or byte lost once ready_i rises.
- Assert rst_i asynchronously mid-frame (element 7) with valid_o high. Expect valid_o=0 immediately; the next frame starts at element 0 and produces correct bytes; frame_count_o=0.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared types and constants for the edge packer and the UART framing path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frame_pkg;

  // Packer phases: pixel payload, partial-byte flush, then the two tail bytes.
  typedef enum logic [1:0] {
    S_DATA  = 2'd0,
    S_FLUSH = 2'd1,
    S_TAIL0 = 2'd2,
    S_TAIL1 = 2'd3
  } state_t;

  // Frame tail markers; the framer and deframer use the same values.
  localparam logic [7:0] TAIL_BYTE0 = 8'hA5;
  localparam logic [7:0] TAIL_BYTE1 = 8'h5A;

endpackage

// File: rtl/edge_threshold.sv
// Reduces one multi-channel signed pixel to a single edge bit for a mode/threshold.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module edge_threshold #(
  parameter int Channels  = 2,
  parameter int ChanWidth = 5,
  parameter int ModeWidth = $clog2(2*Channels+1)
) (
  input  logic [Channels*ChanWidth-1:0] data,
  input  logic [ModeWidth-1:0]          mode,
  input  logic [ChanWidth-1:0]          thresh,
  output logic                          edge_bit
);

  logic [Channels-1:0] ge_signed;
  logic [Channels-1:0] ge_abs;

  // Per-channel comparisons, done one bit wider so |most negative| still fits.
  for (genvar c = 0; c < Channels; c++) begin : g_ch
    logic signed [ChanWidth:0] ext;
    logic        [ChanWidth:0] mag;
    assign ext          = {data[c*ChanWidth+ChanWidth-1], data[c*ChanWidth +: ChanWidth]};
    assign mag          = ext[ChanWidth] ? (~ext + 1'b1) : ext;
    assign ge_signed[c] = ext >= $signed({1'b0, thresh});
    assign ge_abs[c]    = mag >= {1'b0, thresh};
  end

  // Mode select: signed per channel, magnitude per channel, else OR of magnitudes.
  always_comb begin
    edge_bit = |ge_abs;
    for (int c = 0; c < Channels; c++) begin
      if (mode == ModeWidth'(c)) begin
        edge_bit = ge_signed[c];
      end else if (mode == ModeWidth'(Channels + c)) begin
        edge_bit = ge_abs[c];
      end
    end
  end

endmodule

// File: rtl/frame_edge_packer.sv
// Thresholds pixels to edge bits, packs them LSB-first into bytes, and appends a 2-byte tail per frame.
// Latency: a byte is valid the cycle after its last bit is accepted; tail bytes follow back-to-back.
// Backpressure: single output slot reloadable while draining; ready_o drops only when a byte would complete into a full slot.
module frame_edge_packer
  import frame_pkg::*;
#(
  parameter int                  Channels       = 2,
  parameter int                  ChanWidth      = 5,
  parameter int                  BusWidth       = 8,
  parameter int                  PacketLenElems = 318*238,
  parameter logic [BusWidth-1:0] TailByte0      = TAIL_BYTE0,
  parameter logic [BusWidth-1:0] TailByte1      = TAIL_BYTE1,
  parameter int                  ModeWidth      = $clog2(2*Channels+1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [ModeWidth-1:0]          mode_i,
  input  logic [ChanWidth-1:0]          thresh_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [Channels*ChanWidth-1:0] data_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [BusWidth-1:0]           data_o,
  output logic [ModeWidth-1:0]          mode_active_o,
  output logic [15:0]                   frame_count_o
);

  localparam int BitCntW  = $clog2(BusWidth);
  localparam int ElemCntW = $clog2(PacketLenElems + 1);
  localparam logic [BitCntW-1:0]  LastBit  = BitCntW'(BusWidth - 1);
  localparam logic [ElemCntW-1:0] LastElem = ElemCntW'(PacketLenElems - 1);

  state_t                state, state_n;
  logic [ElemCntW-1:0]   elem_cnt;
  logic [BitCntW-1:0]    bit_cnt;
  logic [BusWidth-1:0]   shreg;
  logic [BusWidth-1:0]   cur_byte;
  logic [BusWidth-1:0]   load_dat;
  logic [ChanWidth-1:0]  thresh_act;
  logic [ChanWidth-1:0]  thresh_eff;
  logic [ModeWidth-1:0]  mode_eff;
  logic                  edge_bit;
  logic                  accept;
  logic                  first_elem;
  logic                  last_bit;
  logic                  last_elem;
  logic                  slot_free;
  logic                  load;
  logic                  frame_done;

  // Element 0 uses the live mode/threshold (they are being captured on that same accept).
  assign first_elem = (elem_cnt == '0);
  assign mode_eff   = first_elem ? mode_i   : mode_active_o;
  assign thresh_eff = first_elem ? thresh_i : thresh_act;

  assign last_bit  = (bit_cnt == LastBit);
  assign last_elem = (elem_cnt == LastElem);
  assign slot_free = !valid_o || ready_i;
  assign ready_o   = (state == S_DATA) && !(valid_o && last_bit);
  assign accept    = valid_i && ready_o;

  edge_threshold #(
    .Channels  (Channels),
    .ChanWidth (ChanWidth),
    .ModeWidth (ModeWidth)
  ) u_edge_threshold (
    .data     (data_i),
    .mode     (mode_eff),
    .thresh   (thresh_eff),
    .edge_bit (edge_bit)
  );

  // Place the new bit at its LSB-first slot; a fresh byte starts from zero so flush padding is free.
  always_comb begin
    cur_byte          = (bit_cnt == '0) ? '0 : shreg;
    cur_byte[bit_cnt] = edge_bit;
  end

  // Next-state and output-slot load decisions.
  always_comb begin
    state_n    = state;
    load       = 1'b0;
    load_dat   = cur_byte;
    frame_done = 1'b0;
    unique case (state)
      S_DATA: begin
        if (accept) begin
          load = last_bit;
          if (last_elem) begin
            state_n = last_bit ? S_TAIL0 : S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (slot_free) begin
          load     = 1'b1;
          load_dat = shreg;
          state_n  = S_TAIL0;
        end
      end
      S_TAIL0: begin
        if (slot_free) begin
          load     = 1'b1;
          load_dat = TailByte0;
          state_n  = S_TAIL1;
        end
      end
      S_TAIL1: begin
        if (slot_free) begin
          load       = 1'b1;
          load_dat   = TailByte1;
          frame_done = 1'b1;
          state_n    = S_DATA;
        end
      end
      default: state_n = S_DATA;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_DATA;
    else       state <= state_n;
  end

  // Pixel counters, bit accumulator, frame-boundary mode/threshold capture and frame counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      elem_cnt      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      mode_active_o <= '0;
      thresh_act    <= '0;
      frame_count_o <= '0;
    end else begin
      if (accept) begin
        if (first_elem) begin
          mode_active_o <= mode_i;
          thresh_act    <= thresh_i;
        end
        shreg    <= cur_byte;
        bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
        elem_cnt <= elem_cnt + 1'b1;
      end
      if (frame_done) begin
        elem_cnt      <= '0;
        bit_cnt       <= '0;
        shreg         <= '0;
        frame_count_o <= frame_count_o + 16'd1;
      end
    end
  end

  // Single-entry output slot; may be refilled in the same cycle it drains.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (load) begin
      valid_o <= 1'b1;
      data_o  <= load_dat;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_edge_packer.sv
// Directed bench for frame_edge_packer: a 16-pixel instance and a 10-pixel (flush) instance.
// Inputs change #1 after the rising edge; outputs and handshakes are sampled on the falling edge.
// Every comparison is an immediate assertion counted in checks/errors.
module tb_frame_edge_packer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [2:0]  mode_i;
  logic [4:0]  thresh_i;
  logic [9:0]  data_i;

  logic        valid_a, ready_a, rdy_a, vo_a;
  logic [7:0]  do_a;
  logic [2:0]  mact_a;
  logic [15:0] fc_a;

  logic        valid_b, ready_b, rdy_b, vo_b;
  logic [7:0]  do_b;
  logic [2:0]  mact_b;
  logic [15:0] fc_b;

  int checks = 0;
  int errors = 0;
  int acc_a  = 0;
  int acc_base;
  int pos_a  = 0;
  int pos_b  = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int t1[16] = '{2, 1, -3, 5, 0, 2, 2, -16, 3, 3, 3, 3, -1, -1, -1, -1};

  always #5 clk = ~clk;

  frame_edge_packer #(
    .Channels(2), .ChanWidth(5), .BusWidth(8), .PacketLenElems(16),
    .TailByte0(8'hA5), .TailByte1(8'h5A), .ModeWidth(3)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .thresh_i(thresh_i),
    .valid_i(valid_a), .ready_o(ready_a), .data_i(data_i),
    .valid_o(vo_a), .ready_i(rdy_a), .data_o(do_a),
    .mode_active_o(mact_a), .frame_count_o(fc_a)
  );

  frame_edge_packer #(
    .Channels(2), .ChanWidth(5), .BusWidth(8), .PacketLenElems(10),
    .TailByte0(8'hA5), .TailByte1(8'h5A), .ModeWidth(3)
  ) dut10 (
    .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .thresh_i(thresh_i),
    .valid_i(valid_b), .ready_o(ready_b), .data_i(data_i),
    .valid_o(vo_b), .ready_i(rdy_b), .data_o(do_b),
    .mode_active_o(mact_b), .frame_count_o(fc_b)
  );

  // Record every byte handshake and every pixel accepted by the 16-pixel instance.
  always @(negedge clk) begin
    if (vo_a && rdy_a) q_a.push_back(do_a);
    if (vo_b && rdy_b) q_b.push_back(do_b);
    if (valid_a && ready_a) acc_a++;
  end

  function automatic logic [9:0] pix(input int c0, input int c1);
    logic [31:0] a;
    logic [31:0] b;
    a = c0;
    b = c1;
    return {b[4:0], a[4:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_pix(input bit sel, input logic [9:0] d);
    int n;
    n = 0;
    data_i = d;
    if (sel) valid_b = 1'b1;
    else     valid_a = 1'b1;
    @(negedge clk);
    while (!(sel ? ready_b : ready_a) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(sel ? ready_b : ready_a)) check("accept_timeout", 32'(sel ? ready_b : ready_a), 32'd1);
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  // Wait for four more bytes on the chosen instance and compare them to exp (byte 0 in bits 7:0).
  task automatic expect_frame(input bit sel, input string tag, input logic [31:0] exp);
    int n;
    int base;
    logic [7:0] obs;
    n = 0;
    base = sel ? pos_b : pos_a;
    while ((sel ? q_b.size() : q_a.size()) < base + 4 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check($sformatf("%s_count", tag), 32'(sel ? q_b.size() : q_a.size()), 32'(base + 4));
    for (int i = 0; i < 4; i++) begin
      obs = 8'h00;
      if (sel && base + i < q_b.size()) obs = q_b[base + i];
      if (!sel && base + i < q_a.size()) obs = q_a[base + i];
      check($sformatf("%s_byte%0d", tag, i), 32'(obs), 32'(exp[8*i +: 8]));
    end
    if (sel) pos_b = base + 4;
    else     pos_a = base + 4;
  endtask

  initial begin
    rst_i = 1'b1; mode_i = 3'd0; thresh_i = 5'd0; data_i = '0;
    valid_a = 1'b0; valid_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(vo_a), 32'd0);
    check("rst_data",  32'(do_a), 32'd0);
    check("rst_mode",  32'(mact_a), 32'd0);
    check("rst_fcnt",  32'(fc_a), 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready_a), 32'd1);
    @(posedge clk);
    #1;

    // Frame 1: signed ch0 >= 2, mixed pattern -> 69, 0F, tail.
    mode_i = 3'd0; thresh_i = 5'd2;
    for (int i = 0; i < 16; i++) drive_pix(1'b0, pix(t1[i], 7));
    expect_frame(1'b0, "t1", 32'h5AA50F69);
    check("t1_fcnt", 32'(fc_a), 32'd1);
    check("t1_mode", 32'(mact_a), 32'd0);

    // Frame 2: |ch0| >= 15 with ch0 = -16 everywhere -> FF, FF.
    @(posedge clk); #1;
    mode_i = 3'd2; thresh_i = 5'd15;
    for (int i = 0; i < 16; i++) drive_pix(1'b0, pix(-16, 0));
    expect_frame(1'b0, "t2", 32'h5AA5FFFF);
    check("t2_fcnt", 32'(fc_a), 32'd2);
    check("t2_mode", 32'(mact_a), 32'd2);

    // 10-pixel instance, OR mode: ch0 = 1 then ch1 = -1 -> FF, padded 03, tail.
    @(posedge clk); #1;
    mode_i = 3'd4; thresh_i = 5'd1;
    for (int i = 0; i < 10; i++) drive_pix(1'b1, (i < 5) ? pix(1, 0) : pix(0, -1));
    expect_frame(1'b1, "t3", 32'h5AA503FF);
    check("t3_fcnt", 32'(fc_b), 32'd1);
    // Out-of-range mode 7 behaves as OR mode.
    mode_i = 3'd7;
    for (int i = 0; i < 10; i++) drive_pix(1'b1, (i < 5) ? pix(1, 0) : pix(0, -1));
    expect_frame(1'b1, "t3b", 32'h5AA503FF);
    check("t3b_fcnt", 32'(fc_b), 32'd2);
    check("t3b_mode", 32'(mact_b), 32'd7);

    // Frame 3: mode_i switches 0 -> 1 at element 5; whole frame stays signed ch0 >= 2.
    @(posedge clk); #1;
    mode_i = 3'd0; thresh_i = 5'd2;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) mode_i = 3'd1;
      drive_pix(1'b0, pix(3, 0));
    end
    check("t4_mode_hold", 32'(mact_a), 32'd0);
    expect_frame(1'b0, "t4", 32'h5AA5FFFF);
    check("t4_fcnt", 32'(fc_a), 32'd3);

    // Frame 4: mode 1 (ch1 signed) with downstream stalled for 20 cycles.
    @(posedge clk); #1;
    check("t5_mode_pending", 32'(mact_a), 32'd0);
    acc_base = acc_a;
    data_i = pix(0, 2); valid_a = 1'b1; rdy_a = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_valid_early", 32'(vo_a), 32'd1);
    check("t5_data_early",  32'(do_a), 32'hFF);
    repeat (10) @(negedge clk);
    check("t5_ready_low",   32'(ready_a), 32'd0);
    check("t5_valid_late",  32'(vo_a), 32'd1);
    check("t5_data_late",   32'(do_a), 32'hFF);
    check("t5_accepted",    32'(acc_a - acc_base), 32'd15);
    @(posedge clk); #1;
    rdy_a = 1'b1;
    drive_pix(1'b0, pix(0, 2));
    expect_frame(1'b0, "t5", 32'h5AA5FFFF);
    check("t5_accepted_all", 32'(acc_a - acc_base), 32'd16);
    check("t5_fcnt", 32'(fc_a), 32'd4);
    check("t5_mode", 32'(mact_a), 32'd1);

    // Reset in the middle of a frame with a byte pending in the slot.
    @(posedge clk); #1;
    mode_i = 3'd2; thresh_i = 5'd2; rdy_a = 1'b0;
    for (int i = 0; i < 8; i++) drive_pix(1'b0, pix(3, 0));
    check("t6_pending", 32'(vo_a), 32'd1);
    check("t6_mode_pre", 32'(mact_a), 32'd2);
    #2 rst_i = 1'b1;
    #1;
    check("t6_rst_valid", 32'(vo_a), 32'd0);
    check("t6_rst_data",  32'(do_a), 32'd0);
    check("t6_rst_fcnt",  32'(fc_a), 32'd0);
    check("t6_rst_mode",  32'(mact_a), 32'd0);
    @(posedge clk);
    #3;
    rst_i = 1'b0;
    rdy_a = 1'b1;
    @(posedge clk); #1;
    mode_i = 3'd0; thresh_i = 5'd2;
    for (int i = 0; i < 16; i++) drive_pix(1'b0, pix(t1[i], 7));
    expect_frame(1'b0, "t6", 32'h5AA50F69);
    check("t6_fcnt", 32'(fc_a), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
